bcd_stopwatch_core: RTL and testbench
=====================================

Name: bcd_stopwatch_core

Overview:
- MM:SS stopwatch counter core that sits directly downstream of the 1 Hz tick generator and upstream of the four per-digit hex-to-seven-segment decoders on HEX3..HEX0.
- Consumes a single-cycle tick enable in the clk domain. It does not use a derived clock.
- Turns raw active-low push-buttons into start/pause/clear control.
- Produces four BCD digits plus status.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchroniser stages on each key input (minimum 2).
- WRAP, 1, behaviour at 59:59. 1 means wrap to 00:00 and keep running. 0 means saturate at 59:59 and pause.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  one-clk-cycle pulse at 1 Hz from the tick generator.
- key_start_n  input  1  raw start/pause push-button, active-low, asynchronous to clk.
- key_clear_n  input  1  raw clear push-button, active-low, asynchronous to clk.
- sec_ones  output  4  BCD seconds units, 0-9.
- sec_tens  output  4  BCD seconds tens, 0-5.
- min_ones  output  4  BCD minutes units, 0-9.
- min_tens  output  4  BCD minutes tens, 0-5.
- running  output  1  high while in state RUN.
- rollover  output  1  one-cycle pulse when the count passes 59:59.

Behaviour:
- Reset (asynchronous, active-low):
  - All digits 0; running=0; rollover=0; state=IDLE.
  - Synchroniser flops reset to 1 (key released).
- Key handling:
  - Each key passes through SYNC_STAGES flops, then a falling-edge detector, producing a one-cycle press event.
  - Latency from key falling to state/digit change is SYNC_STAGES+1 clk edges.
  - A held key generates exactly one event. No debounce: bounce handling is upstream, in board RC.
- State machine (registered):
  - IDLE: start event -> RUN.
  - RUN: start event -> PAUSE.
  - PAUSE: start event -> RUN.
  - Any state: clear event -> IDLE and all digits zeroed on the same edge.
  - Clear wins over a simultaneous start event.
- Counting:
  - Only in RUN, on a clk edge where tick=1. Digits update on that edge.
  - Tick ignored in IDLE and PAUSE.
  - Tick and start/clear events in the same cycle: the state and count update use the pre-edge state. Example: RUN + tick + start -> count increments and state becomes PAUSE.
  - Cascade: sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into min_ones; min_ones 9->0 carries into min_tens; min_tens 5 with carry is the rollover.
- Rollover at 59:59 + tick:
  - WRAP=1: digits -> 00:00, rollover=1 for one cycle, stay in RUN.
  - WRAP=0: digits hold 59:59, rollover=1 for one cycle, state -> PAUSE.
  - With WRAP=0, a subsequent start from PAUSE at 59:59 -> RUN, next tick repeats the saturate behaviour.
- Outputs are registered and never hold non-BCD values. Any digit found >9 is forced to 0 on the next counted tick.

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- When defined:
  - Adds input key_lap_n (1 bit, active-low, same synchroniser/edge path as the other keys).
  - A lap event in RUN snapshots the count into a display register. The outputs show the snapshot while the internal count continues.
  - A second lap event releases the hold, and the outputs track the count again from the next cycle.
  - Clear releases the hold and zeroes both the count and the snapshot.
  - Lap events in IDLE or PAUSE are ignored.
- When undefined: no key_lap_n port; the outputs are the count registers directly.

Decomposition:
- Package stopwatch_pkg holds:
  - State enum (IDLE, RUN, PAUSE).
  - 4-bit BCD digit typedef.
  - Constants SEC_TENS_MAX=5, MIN_TENS_MAX=5, DIGIT_MAX=9.
- Sub-module bcd_digit: one BCD counter with parameter MAX, inputs inc and clr, outputs digit and carry (carry = inc & digit==MAX). Instantiated four times in a chain.
- Synchroniser and edge-detect logic stays inline.

Test Plan:
- Reset then 5 ticks with no key press -> digits stay 00:00, running=0.
- Press start, wait SYNC_STAGES+1 cycles, then 61 ticks -> running=1, outputs 01:01.
- At 00:09 press start (pause), apply 3 ticks, press start again, apply 1 tick -> 00:09 held while paused, then 00:10.
- Preload to 59:58 via ticks, 2 ticks, WRAP=1 -> 59:59 then 00:00 with a rollover pulse lasting exactly 1 cycle. With WRAP=0 -> holds 59:59, running=0.
- Start and clear pressed in the same cycle while in RUN at 12:34 -> 00:00, state IDLE, running=0.
- Assert reset mid-RUN at 03:27 -> immediate 00:00, running=0. After release, a tick with no start -> still 00:00.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch core.
package stopwatch_pkg;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    localparam int unsigned DIGIT_W = 4;

    // One packed BCD digit
    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
    localparam bcd_digit_t MIN_TENS_MAX = 4'd5;
    localparam bcd_digit_t DIGIT_MAX    = 4'd9;

    // Full MM:SS count, most significant digit first
    typedef struct packed {
        bcd_digit_t min_tens;
        bcd_digit_t min_ones;
        bcd_digit_t sec_tens;
        bcd_digit_t sec_ones;
    } bcd_time_t;

    localparam bcd_time_t TIME_MAX = '{
        min_tens: MIN_TENS_MAX,
        min_ones: DIGIT_MAX,
        sec_tens: SEC_TENS_MAX,
        sec_ones: DIGIT_MAX
    };

endpackage

// File: rtl/bcd_digit.sv
// Single BCD counter stage: counts 0..MAX, carries out when stepping past MAX.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_digit_t MAX = DIGIT_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    input  logic       scrub,
    output bcd_digit_t digit,
    output logic       carry
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    // Next digit: clear dominates, then increment/wrap, then repair of any non-BCD value
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = (digit_q >= MAX) ? '0 : bcd_digit_t'(digit_q + 4'd1);
        end else if (scrub && (digit_q > DIGIT_MAX)) begin
            digit_d = '0;
        end
    end

    // Digit register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = inc & (digit_q == MAX);

endmodule

// File: rtl/bcd_stopwatch_core.sv
// MM:SS stopwatch core: key synchronisers, start/pause/clear FSM, BCD digit chain.
// Optional lap/hold display enabled by defining STOPWATCH_LAP_HOLD_EN.
module bcd_stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WRAP        = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_start_n,
    input  logic       key_clear_n,
`ifdef STOPWATCH_LAP_HOLD_EN
    input  logic       key_lap_n,
`endif
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover
);

    localparam int unsigned KEY_START = 0;
    localparam int unsigned KEY_CLEAR = 1;
`ifdef STOPWATCH_LAP_HOLD_EN
    localparam int unsigned KEY_LAP   = 2;
    localparam int unsigned NUM_KEYS  = 3;
`else
    localparam int unsigned NUM_KEYS  = 2;
`endif
    localparam logic SATURATE = (WRAP == 0);

    logic [NUM_KEYS-1:0]                  keys_raw_n;
    logic [NUM_KEYS-1:0][SYNC_STAGES-1:0] sync_q;
    logic [NUM_KEYS-1:0][SYNC_STAGES-1:0] sync_d;
    logic [NUM_KEYS-1:0]                  key_prev_q;
    logic [NUM_KEYS-1:0]                  key_prev_d;
    logic [NUM_KEYS-1:0]                  key_ev_c;

    sw_state_e state_q;
    sw_state_e state_d;
    logic      running_q;
    logic      running_d;
    logic      rollover_q;
    logic      rollover_d;

    logic      start_ev_c;
    logic      clear_ev_c;
    logic      count_en_c;
    logic      at_max_c;
    logic      inc_c;
    logic      roll_c;
    logic      carry_so_c;
    logic      carry_st_c;
    logic      carry_mo_c;
    logic      carry_mt_c;
    bcd_time_t cnt;
    bcd_time_t disp;

`ifdef STOPWATCH_LAP_HOLD_EN
    assign keys_raw_n = {key_lap_n, key_clear_n, key_start_n};
`else
    assign keys_raw_n = {key_clear_n, key_start_n};
`endif

    // Shift each raw key into its synchroniser; a high-to-low step at the output is a press
    always_comb begin
        sync_d     = sync_q;
        key_prev_d = key_prev_q;
        key_ev_c   = '0;
        for (int k = 0; k < int'(NUM_KEYS); k++) begin
            sync_d[k]     = {sync_q[k][SYNC_STAGES-2:0], keys_raw_n[k]};
            key_prev_d[k] = sync_q[k][SYNC_STAGES-1];
            key_ev_c[k]   = key_prev_q[k] & ~sync_q[k][SYNC_STAGES-1];
        end
    end

    // Synchroniser and edge-detect flops; released-key level on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '1;
            key_prev_q <= '1;
        end else begin
            sync_q     <= sync_d;
            key_prev_q <= key_prev_d;
        end
    end

    assign start_ev_c = key_ev_c[KEY_START];
    assign clear_ev_c = key_ev_c[KEY_CLEAR];

    // Count qualification; in saturate mode the chain is frozen at 59:59
    assign count_en_c = (state_q == RUN) & tick;
    assign at_max_c   = (cnt == TIME_MAX);
    assign inc_c      = count_en_c & ~(SATURATE & at_max_c);
    assign roll_c     = carry_mt_c | (count_en_c & SATURATE & at_max_c);

    bcd_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_c),
        .clr   (clear_ev_c),
        .scrub (count_en_c),
        .digit (cnt.sec_ones),
        .carry (carry_so_c)
    );

    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk   (clk),
        .reset (reset),
        .inc   (carry_so_c),
        .clr   (clear_ev_c),
        .scrub (count_en_c),
        .digit (cnt.sec_tens),
        .carry (carry_st_c)
    );

    bcd_digit #(.MAX(DIGIT_MAX)) u_min_ones (
        .clk   (clk),
        .reset (reset),
        .inc   (carry_st_c),
        .clr   (clear_ev_c),
        .scrub (count_en_c),
        .digit (cnt.min_ones),
        .carry (carry_mo_c)
    );

    bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk   (clk),
        .reset (reset),
        .inc   (carry_mo_c),
        .clr   (clear_ev_c),
        .scrub (count_en_c),
        .digit (cnt.min_tens),
        .carry (carry_mt_c)
    );

    // Next state and registered status; clear overrides every other transition
    always_comb begin
        state_d    = state_q;
        running_d  = 1'b0;
        rollover_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ev_c) state_d = RUN;
            end
            RUN: begin
                if (start_ev_c || (SATURATE && roll_c)) state_d = PAUSE;
            end
            PAUSE: begin
                if (start_ev_c) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        if (clear_ev_c) state_d = IDLE;
        running_d  = (state_d == RUN);
        rollover_d = roll_c & ~clear_ev_c;
    end

    // State and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            running_q  <= running_d;
            rollover_q <= rollover_d;
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    logic      hold_q;
    logic      hold_d;
    bcd_time_t snap_q;
    bcd_time_t snap_d;

    // Lap toggles between snapshot display and live count, only while running
    always_comb begin
        hold_d = hold_q;
        snap_d = snap_q;
        if (clear_ev_c) begin
            hold_d = 1'b0;
            snap_d = '0;
        end else if (key_ev_c[KEY_LAP] && (state_q == RUN)) begin
            if (hold_q) begin
                hold_d = 1'b0;
            end else begin
                hold_d = 1'b1;
                snap_d = cnt;
            end
        end
    end

    // Lap hold and snapshot registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= 1'b0;
            snap_q <= '0;
        end else begin
            hold_q <= hold_d;
            snap_q <= snap_d;
        end
    end

    assign disp = hold_q ? snap_q : cnt;
`else
    assign disp = cnt;
`endif

    assign sec_ones = disp.sec_ones;
    assign sec_tens = disp.sec_tens;
    assign min_ones = disp.min_ones;
    assign min_tens = disp.min_tens;
    assign running  = running_q;
    assign rollover = rollover_q;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Scoreboard bench for bcd_stopwatch_core: one wrapping and one saturating instance share stimulus.
module tb_bcd_stopwatch_core;

    localparam int unsigned SYNC = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic key_start_n = 1'b1;
    logic key_clear_n = 1'b1;

    logic [3:0] w_so, w_st, w_mo, w_mt;
    logic       w_run, w_roll;
    logic [3:0] s_so, s_st, s_mo, s_mt;
    logic       s_run, s_roll;

    always #10 clk = ~clk;

    bcd_stopwatch_core #(.SYNC_STAGES(SYNC), .WRAP(1)) dut_wrap (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .key_start_n (key_start_n),
        .key_clear_n (key_clear_n),
`ifdef STOPWATCH_LAP_HOLD_EN
        .key_lap_n   (1'b1),
`endif
        .sec_ones    (w_so),
        .sec_tens    (w_st),
        .min_ones    (w_mo),
        .min_tens    (w_mt),
        .running     (w_run),
        .rollover    (w_roll)
    );

    bcd_stopwatch_core #(.SYNC_STAGES(SYNC), .WRAP(0)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .key_start_n (key_start_n),
        .key_clear_n (key_clear_n),
`ifdef STOPWATCH_LAP_HOLD_EN
        .key_lap_n   (1'b1),
`endif
        .sec_ones    (s_so),
        .sec_tens    (s_st),
        .min_ones    (s_mo),
        .min_tens    (s_mt),
        .running     (s_run),
        .rollover    (s_roll)
    );

    typedef struct {
        string       name;
        bit          sel;      // 0: wrapping instance, 1: saturating instance
        logic [15:0] digits;   // {min_tens, min_ones, sec_tens, sec_ones}
        logic        run;
        logic        roll;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic expect_out(input string name, input bit sel, input logic [15:0] d,
                              input logic r, input logic ro);
        exp_t e;
        e.name = name; e.sel = sel; e.digits = d; e.run = r; e.roll = ro;
        sb.push_back(e);
    endtask

    task automatic expect_both(input string name, input logic [15:0] d, input logic r);
        expect_out(name, 1'b0, d, r, 1'b0);
        expect_out(name, 1'b1, d, r, 1'b0);
    endtask

    // Monitor: compare every pending expectation on the falling edge
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] ad;
        logic        ar;
        logic        aro;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            ad  = e.sel ? {s_mt, s_mo, s_st, s_so} : {w_mt, w_mo, w_st, w_so};
            ar  = e.sel ? s_run  : w_run;
            aro = e.sel ? s_roll : w_roll;
            checks++;
            if (ad !== e.digits || ar !== e.run || aro !== e.roll) begin
                errors++;
                $display("FAIL %s[%s]: got digits=%h running=%b rollover=%b, want digits=%h running=%b rollover=%b",
                         e.name, e.sel ? "sat" : "wrap", ad, ar, aro, e.digits, e.run, e.roll);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick_once();
    endtask

    // Hold keys low until the event has acted (SYNC+1 edges), optionally with a tick on that edge
    task automatic press(input bit s, input bit c, input bit t);
        key_start_n = ~s;
        key_clear_n = ~c;
        repeat (SYNC) step();
        tick = t;
        step();
        tick = 1'b0;
        key_start_n = 1'b1;
        key_clear_n = 1'b1;
        repeat (SYNC + 1) step();
    endtask

    initial begin
        int n;

        // Reset, then ticks with no start must not count
        repeat (3) step();
        reset = 1'b1;
        step();
        expect_both("reset", 16'h0000, 1'b0);
        ticks(5);
        expect_both("idle_ticks", 16'h0000, 1'b0);

        // Start and count 61 seconds
        press(1'b1, 1'b0, 1'b0);
        expect_both("start", 16'h0000, 1'b1);
        ticks(61);
        expect_both("count_61", 16'h0101, 1'b1);

        // Pause at 00:09, ticks ignored, resume
        press(1'b0, 1'b1, 1'b0);
        expect_both("clear", 16'h0000, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        ticks(9);
        expect_both("count_9", 16'h0009, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        expect_both("pause", 16'h0009, 1'b0);
        ticks(3);
        expect_both("paused_ticks", 16'h0009, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        expect_both("resume", 16'h0009, 1'b1);
        ticks(1);
        expect_both("carry_sec_tens", 16'h0010, 1'b1);
        press(1'b1, 1'b0, 1'b1);
        expect_both("tick_with_pause", 16'h0011, 1'b0);

        // Run up to 59:58, then the 59:59 boundary
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        ticks(3598);
        expect_both("at_5958", 16'h5958, 1'b1);
        tick = 1'b1; step(); tick = 1'b0;
        expect_both("at_5959", 16'h5959, 1'b1);
        tick = 1'b1; step(); tick = 1'b0;
        expect_out("roll_edge", 1'b0, 16'h0000, 1'b1, 1'b1);
        expect_out("roll_edge", 1'b1, 16'h5959, 1'b0, 1'b1);
        step();
        expect_out("roll_after", 1'b0, 16'h0000, 1'b1, 1'b0);
        expect_out("roll_after", 1'b1, 16'h5959, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        expect_out("restart_at_max", 1'b0, 16'h0000, 1'b0, 1'b0);
        expect_out("restart_at_max", 1'b1, 16'h5959, 1'b1, 1'b0);
        tick = 1'b1; step(); tick = 1'b0;
        expect_out("resaturate", 1'b0, 16'h0000, 1'b0, 1'b0);
        expect_out("resaturate", 1'b1, 16'h5959, 1'b0, 1'b1);
        step();
        expect_out("resaturate_after", 1'b1, 16'h5959, 1'b0, 1'b0);

        // Simultaneous start and clear at 12:34
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        ticks(754);
        expect_both("at_1234", 16'h1234, 1'b1);
        press(1'b1, 1'b1, 1'b0);
        expect_both("clear_wins", 16'h0000, 1'b0);
        ticks(1);
        expect_both("idle_after_clear", 16'h0000, 1'b0);

        // Asynchronous reset mid-run at 03:27
        press(1'b1, 1'b0, 1'b0);
        ticks(207);
        expect_both("at_0327", 16'h0327, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        expect_both("async_reset", 16'h0000, 1'b0);
        step();
        reset = 1'b1;
        step();
        ticks(1);
        expect_both("post_reset_tick", 16'h0000, 1'b0);

        // Drain the scoreboard with a bounded wait
        n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
